// File: rtl/multi_sev_seg_scan_if.sv
// Display bus between the datapath (master) and the seven-segment scanner (slave).
// Carries the packed hex value, load strobe, per-digit controls and the pin-level outputs.
interface multi_sev_seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    lz_blank;
  logic [6:0]              segment;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    frame_done;

  modport master (
    output value, load, digit_en, dp, lz_blank,
    input  segment, dp_n, anode, frame_done
  );

  modport slave (
    input  value, load, digit_en, dp, lz_blank,
    output segment, dp_n, anode, frame_done
  );
endinterface

// File: rtl/multi_sev_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous
// double buffering, per-digit enable/decimal point and leading-zero blanking.
module multi_sev_seg_scan #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_sev_seg_scan_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic [VAL_W-1:0]      pending, pending_nx;
  logic                  pend_valid, pend_valid_nx;
  logic [VAL_W-1:0]      display, display_nx;
  logic [6:0]            seg_q, seg_nx;
  logic                  dp_n_q, dp_n_nx;
  logic [NUM_DIGITS-1:0] anode_q, anode_nx;
  logic                  frame_done_q, frame_done_nx;

  logic                  slot_end, frame_end, blank, run;
  logic [3:0]            nibble;
  logic [NUM_DIGITS-1:0] zero_from;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      pending      <= '0;
      pend_valid   <= 1'b0;
      display      <= '0;
      seg_q        <= 7'b1111111;
      dp_n_q       <= 1'b1;
      anode_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt          <= cnt_nx;
      idx          <= idx_nx;
      pending      <= pending_nx;
      pend_valid   <= pend_valid_nx;
      display      <= display_nx;
      seg_q        <= seg_nx;
      dp_n_q       <= dp_n_nx;
      anode_q      <= anode_nx;
      frame_done_q <= frame_done_nx;
    end
  end

  // Prescaler, buffering and decode of the current slot
  always_comb begin
    cnt_nx        = cnt + CNT_W'(1);
    idx_nx        = idx;
    pending_nx    = pending;
    pend_valid_nx = pend_valid;
    display_nx    = display;
    run           = 1'b1;
    zero_from     = '0;

    slot_end  = (cnt == CNT_W'(REFRESH_DIV - 1));
    frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

    if (slot_end) begin
      cnt_nx = '0;
      idx_nx = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end

    // Swap first so a load on the frame-end edge lands in pending for next frame
    if (frame_end && pend_valid) begin
      display_nx    = pending;
      pend_valid_nx = 1'b0;
    end
    if (bus.load) begin
      pending_nx    = bus.value;
      pend_valid_nx = 1'b1;
    end

    // zero_from[i]: digits i..NUM_DIGITS-1 are all zero
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      run          = run & (display[4*i +: 4] == 4'h0);
      zero_from[i] = run;
    end

    nibble = display[{idx, 2'b00} +: 4];
    blank  = !bus.digit_en[idx] || (bus.lz_blank && (idx != '0) && zero_from[idx]);

    seg_nx        = blank ? 7'b1111111 : decode(nibble);
    dp_n_nx       = blank | ~bus.dp[idx];
    anode_nx      = (blank || (cnt == '0)) ? '1 : ~(NUM_DIGITS'(1) << idx);
    frame_done_nx = frame_end;
  end

  assign bus.segment    = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.anode      = anode_q;
  assign bus.frame_done = frame_done_q;

endmodule
